// File: rtl/clock_logic_gate_control.sv
// Clock-domain responder for the async enable handshake: synchronizes the request,
// sequences the ICG enable with programmable settle times and returns a four-phase ack.
// Gate follows the synchronized request SYNC_STAGES cycles after capture; ack follows
// the gate after START_DELAY / STOP_DELAY further cycles; no backpressure.

module clock_logic_gate_control #(
    parameter int SYNC_STAGES = 2,
    parameter int START_DELAY = 4,
    parameter int STOP_DELAY  = 4
) (
    input  logic clock,
    input  logic async_resetn,
    input  logic async_enable,
    output logic async_enable_ack,
    input  logic test_enable,
    output logic gate_enable,
    output logic clock_active,
    output logic busy
);

    // The settle counter must hold the larger of the two delays minus one.
    localparam int MAX_DELAY = (START_DELAY > STOP_DELAY) ? START_DELAY : STOP_DELAY;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_DELAY - 1);

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_STARTING = 2'd1,
        S_ON       = 2'd2,
        S_STOPPING = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   enable_sync;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   gate_reg;
    logic                   ack_reg;
    logic                   busy_reg;

    // Multi-flop synchronizer; the request is only ever observed through the last stage.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_enable};
        end
    end

    assign enable_sync = sync_q[SYNC_STAGES-1];

    // Handshake sequencer. Outputs are registered alongside the state so that the gate
    // and the ack never change on the same edge, and neither can glitch.
    // STARTING and STOPPING always run to completion; a request change that arrives
    // meanwhile is picked up from the following stable state, keeping the ack four-phase.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state    <= S_OFF;
            cnt      <= '0;
            gate_reg <= 1'b0;
            ack_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    if (enable_sync) begin
                        state    <= S_STARTING;
                        cnt      <= '0;
                        gate_reg <= 1'b1;
                        busy_reg <= 1'b1;
                    end
                end

                S_STARTING: begin
                    // Gate is open; wait for the gated clock to settle before acking.
                    if (cnt == START_LAST) begin
                        state    <= S_ON;
                        ack_reg  <= 1'b1;
                        busy_reg <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_ON: begin
                    if (!enable_sync) begin
                        state    <= S_STOPPING;
                        cnt      <= '0;
                        gate_reg <= 1'b0;
                        busy_reg <= 1'b1;
                    end
                end

                S_STOPPING: begin
                    // Gate is closed; keep ack high until downstream logic is quiescent.
                    if (cnt == STOP_LAST) begin
                        state    <= S_OFF;
                        ack_reg  <= 1'b0;
                        busy_reg <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= S_OFF;
                    cnt      <= '0;
                    gate_reg <= 1'b0;
                    ack_reg  <= 1'b0;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    // The test override only forces the ICG open; the handshake never sees it.
    assign gate_enable      = gate_reg | test_enable;
    assign clock_active     = gate_reg;
    assign async_enable_ack = ack_reg;
    assign busy             = busy_reg;

endmodule
